// File: rtl/ddr4_rd_pkg.sv
// Shared definitions for the DDR4 read-port arbiter.
//   - Fixed AXI AR attributes for single-beat 64-byte reads.
//   - Default base addresses of the read regions used by the clients.
//   - Helper that sizes a client-index field for a given client count.
package ddr4_rd_pkg;

  localparam logic [7:0]  ARLEN_SINGLE = 8'd0;
  localparam logic [2:0]  ARSIZE_64B   = 3'b110;
  localparam logic [1:0]  ARBURST_INCR = 2'b01;

  localparam logic [31:0] X00_BASE     = 32'h0030_0000;
  localparam logic [31:0] P00_BASE     = 32'h0040_0000;

  // Width of a client-index field; never narrower than one bit.
  function automatic int req_idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rd_order_fifo.sv
// In-order tracking FIFO of granted client indices.
// Each AR grant pushes the client index; each returned R beat pops the head,
// so the head always names the client that owns the next beat.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears pointers/count)
//   push, push_idx write a client index at the tail
//   pop            drop the head entry
//   head_idx       client index at the head (meaningful only when !empty)
//   count          number of stored entries, 0..DEPTH
//   empty          count == 0
module rd_order_fifo
  import ddr4_rd_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDX_W = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_idx;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_idx = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/ddr4_read_arbiter.sv
// Shares the single-beat 512-bit DDR4 AXI read port between N_REQ clients.
// AR requests are granted round-robin, one per cycle at most, and the granted
// client index is queued so R beats are steered back in issue order with up
// to OUTSTANDING reads in flight.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_araddr/arvalid/arready     per-client AR channel (arready one-hot/zero)
//   req_rdata/rvalid/rready        per-client R channel (data broadcast)
//   axi_ar*                        DDR4 AR channel (single-beat INCR, 64 B)
//   axi_rdata/rvalid/rready        DDR4 R channel
//   busy                           reads in flight or AR pending
//   err_unexp_r                    sticky: R beat with nothing outstanding
module ddr4_read_arbiter
  import ddr4_rd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_araddr,
  input  logic [N_REQ-1:0]              req_arvalid,
  output logic [N_REQ-1:0]              req_arready,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [N_REQ-1:0]              req_rvalid,
  input  logic [N_REQ-1:0]              req_rready,
  output logic [ADDR_W-1:0]             axi_araddr,
  output logic [7:0]                    axi_arlen,
  output logic [2:0]                    axi_arsize,
  output logic [1:0]                    axi_arburst,
  output logic                          axi_arvalid,
  input  logic                          axi_arready,
  input  logic [DATA_W-1:0]             axi_rdata,
  input  logic                          axi_rvalid,
  output logic                          axi_rready,
  output logic                          busy,
  output logic                          err_unexp_r
);

  localparam int IDX_W = req_idx_w(N_REQ);
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  typedef logic [IDX_W-1:0] req_idx_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
  localparam req_idx_t         LAST_IDX = req_idx_t'(N_REQ - 1);

  req_idx_t         last_grant;
  req_idx_t         cand;
  req_idx_t         gnt_idx;
  logic             gnt_found;
  logic             eligible;
  logic             grant;
  req_idx_t         head_idx;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             pop;

  assign axi_arlen   = ARLEN_SINGLE;
  assign axi_arsize  = ARSIZE_64B;
  assign axi_arburst = ARBURST_INCR;

  // Round-robin search starting one past the last granted client.
  always_comb begin
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = req_idx_t'((int'(last_grant) + i) % N_REQ);
      if (!gnt_found && req_arvalid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The registered count already includes a read parked on the AR channel,
  // and a same-cycle pop does not free a slot for a grant.
  assign eligible = (!axi_arvalid || axi_arready) && (fifo_count < MAX_CNT);
  assign grant    = eligible && gnt_found;

  always_comb begin
    req_arready = '0;
    if (grant) req_arready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      last_grant  <= LAST_IDX;
      err_unexp_r <= 1'b0;
    end else begin
      if (grant) begin
        axi_araddr  <= req_araddr[gnt_idx];
        axi_arvalid <= 1'b1;
        last_grant  <= gnt_idx;
      end else if (axi_arready) begin
        axi_arvalid <= 1'b0;
      end
      if (fifo_empty && axi_rvalid) err_unexp_r <= 1'b1;
    end
  end

  // R steering follows the FIFO head; nothing is routed when it is empty.
  always_comb begin
    req_rvalid = '0;
    axi_rready = 1'b0;
    if (!fifo_empty) begin
      req_rvalid[head_idx] = axi_rvalid;
      axi_rready           = req_rready[head_idx];
    end
  end

  assign req_rdata = axi_rdata;
  assign pop       = axi_rvalid && axi_rready;
  assign busy      = !fifo_empty || axi_arvalid;

  rd_order_fifo #(
    .DEPTH (OUTSTANDING),
    .IDX_W (IDX_W)
  ) u_order_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant),
    .push_idx (gnt_idx),
    .pop      (pop),
    .head_idx (head_idx),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ddr4_read_arbiter.sv
// Bench for ddr4_read_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the arbitration and
// in-order return rules.
module tb_ddr4_read_arbiter;
  import ddr4_rd_pkg::*;

  localparam int N_REQ       = 4;
  localparam int OUTSTANDING = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 512;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N_REQ-1:0][ADDR_W-1:0] req_araddr;
  logic [N_REQ-1:0]             req_arvalid;
  logic [N_REQ-1:0]             req_arready;
  logic [DATA_W-1:0]            req_rdata;
  logic [N_REQ-1:0]             req_rvalid;
  logic [N_REQ-1:0]             req_rready;
  logic [ADDR_W-1:0]            axi_araddr;
  logic [7:0]                   axi_arlen;
  logic [2:0]                   axi_arsize;
  logic [1:0]                   axi_arburst;
  logic                         axi_arvalid;
  logic                         axi_arready;
  logic [DATA_W-1:0]            axi_rdata;
  logic                         axi_rvalid;
  logic                         axi_rready;
  logic                         busy;
  logic                         err_unexp_r;

  always #5 clk = ~clk;

  ddr4_read_arbiter #(
    .N_REQ(N_REQ), .OUTSTANDING(OUTSTANDING), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_araddr(req_araddr), .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy(busy), .err_unexp_r(err_unexp_r)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: rotation pointer, queue of owners of outstanding reads,
  // the AR slot towards DDR4 and the sticky error.
  int          lg;
  int          q[$];
  logic        arv_m;
  logic [31:0] araddr_m;
  logic        err_m;
  int          g_m;

  logic [N_REQ-1:0] obs_arready;
  logic [N_REQ-1:0] obs_rvalid;
  logic             obs_rready;
  logic [31:0]      ar_log[$];
  int               r_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    lg       = N_REQ - 1;
    q.delete();
    arv_m    = 1'b0;
    araddr_m = '0;
    err_m    = 1'b0;
  endfunction

  task automatic check_all();
    logic [N_REQ-1:0] e_arr;
    logic [N_REQ-1:0] e_rv;
    logic             e_rr;
    bit               elig;
    int               g;
    elig = (!arv_m || axi_arready) && (q.size() < OUTSTANDING);
    g = -1;
    if (elig) begin
      for (int i = 1; i <= N_REQ; i++) begin
        int c;
        c = (lg + i) % N_REQ;
        if (g < 0 && req_arvalid[c]) g = c;
      end
    end
    g_m   = g;
    e_arr = '0;
    if (g >= 0) e_arr[g] = 1'b1;
    e_rv = '0;
    e_rr = 1'b0;
    if (q.size() > 0) begin
      e_rv[q[0]] = axi_rvalid;
      e_rr       = req_rready[q[0]];
    end
    chk("req_arready", req_arready, e_arr);
    chk("req_rvalid", req_rvalid, e_rv);
    chk("axi_rready", axi_rready, e_rr);
    chk("axi_arvalid", axi_arvalid, arv_m);
    chk("axi_araddr", axi_araddr, araddr_m);
    chk("busy", busy, (q.size() > 0) || arv_m);
    chk("err_unexp_r", err_unexp_r, err_m);
    chk("count", dut.fifo_count, q.size());
    if (e_rv != '0) begin
      tests++;
      assert (req_rdata === axi_rdata) else begin
        fails++;
        $error("FAIL req_rdata: observed %0h expected %0h", req_rdata, axi_rdata);
      end
    end
    obs_arready = req_arready;
    obs_rvalid  = req_rvalid;
    obs_rready  = axi_rready;
    if (axi_arvalid && axi_arready) ar_log.push_back(axi_araddr);
    for (int k = 0; k < N_REQ; k++)
      if (req_rvalid[k] && req_rready[k]) r_log.push_back(k);
  endtask

  function automatic void model_update();
    bit pop;
    if (rst) begin
      model_reset();
    end else begin
      pop = (q.size() > 0) && axi_rvalid && req_rready[q[0]];
      if (q.size() == 0 && axi_rvalid) err_m = 1'b1;
      if (pop) void'(q.pop_front());
      if (g_m >= 0) begin
        q.push_back(g_m);
        arv_m    = 1'b1;
        araddr_m = req_araddr[g_m];
        lg       = g_m;
      end else if (axi_arready) begin
        arv_m = 1'b0;
      end
    end
  endfunction

  // Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
  task automatic tick();
    #4;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_arvalid = '0;
    req_rready  = '1;
    axi_arready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (q.size() == 0 && !arv_m) break;
      axi_rvalid = (q.size() > 0);
      axi_rdata  = {16{$urandom()}};
      tick();
    end
    axi_rvalid = 1'b0;
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    int n_left;
    rst         = 1'b1;
    req_araddr  = '0;
    req_arvalid = '0;
    req_rready  = '0;
    axi_arready = 1'b0;
    axi_rdata   = '0;
    axi_rvalid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state and fixed AR attributes.
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_araddr", axi_araddr, 32'h0);
    chk("rst_err", err_unexp_r, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("arlen", axi_arlen, 8'd0);
    chk("arsize", axi_arsize, 3'b110);
    chk("arburst", axi_arburst, 2'b01);

    // Single read from client 0.
    axi_arready   = 1'b1;
    req_araddr[0] = X00_BASE;
    req_arvalid   = 4'b0001;
    tick();
    req_arvalid = '0;
    chk("t1_araddr", axi_araddr, 32'h0030_0000);
    chk("t1_arvalid", axi_arvalid, 1'b1);
    tick();
    axi_rvalid = 1'b1;
    axi_rdata  = {64{8'hA5}};
    req_rready = 4'b0001;
    tick();
    chk("t1_rvalid", obs_rvalid, 4'b0001);
    axi_rvalid = 1'b0;
    tick();

    // Three clients together, each holding until accepted.
    reset_pulse();
    ar_log.delete();
    r_log.delete();
    req_araddr[0] = 32'h100;
    req_araddr[1] = 32'h200;
    req_araddr[2] = 32'h300;
    req_arvalid   = 4'b0111;
    for (int n = 0; n < 10 && req_arvalid != '0; n++) begin
      tick();
      req_arvalid = req_arvalid & ~obs_arready;
    end
    tick();
    chk("t2_ar_cnt", ar_log.size(), 3);
    if (ar_log.size() == 3) begin
      chk("t2_ar0", ar_log[0], 32'h100);
      chk("t2_ar1", ar_log[1], 32'h200);
      chk("t2_ar2", ar_log[2], 32'h300);
    end
    req_rready = '1;
    axi_rvalid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      axi_rdata = {16{$urandom()}};
      tick();
    end
    axi_rvalid = 1'b0;
    chk("t2_r_cnt", r_log.size(), 3);
    if (r_log.size() == 3) begin
      chk("t2_r0", r_log[0], 0);
      chk("t2_r1", r_log[1], 1);
      chk("t2_r2", r_log[2], 2);
    end

    // Five requests, no returns: the tracker caps at OUTSTANDING.
    reset_pulse();
    req_rready    = 4'b0001;
    req_araddr[0] = P00_BASE;
    n_left        = 5;
    for (int n = 0; n < 8; n++) begin
      req_arvalid = {3'b000, n_left > 0};
      tick();
      if (obs_arready[0]) n_left--;
    end
    chk("t3_issued", 5 - n_left, 4);
    chk("t3_count", dut.fifo_count, 3'd4);
    req_arvalid = 4'b0001;
    axi_rvalid  = 1'b1;
    axi_rdata   = {16{$urandom()}};
    tick();
    chk("t3_no_grant_on_pop", obs_arready, 4'b0000);
    axi_rvalid = 1'b0;
    tick();
    chk("t3_grant_after_pop", obs_arready, 4'b0001);
    drain();

    // Head client stalls its R ready for three cycles.
    reset_pulse();
    req_araddr[1] = 32'h0000_1040;
    req_arvalid   = 4'b0010;
    tick();
    req_arvalid = '0;
    tick();
    req_rready = 4'b0000;
    axi_rvalid = 1'b1;
    axi_rdata  = {16{$urandom()}};
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t4_rready_held", obs_rready, 1'b0);
      chk("t4_rvalid1", obs_rvalid, 4'b0010);
    end
    req_rready = 4'b0010;
    tick();
    chk("t4_pop", obs_rready, 1'b1);
    axi_rvalid = 1'b0;
    chk("t4_idle", busy, 1'b0);

    // Unexpected beat with nothing outstanding.
    axi_rvalid = 1'b1;
    req_rready = '1;
    tick();
    chk("t5_rready", obs_rready, 1'b0);
    chk("t5_rvalid", obs_rvalid, 4'b0000);
    axi_rvalid = 1'b0;
    chk("t5_err_set", err_unexp_r, 1'b1);
    repeat (3) tick();
    chk("t5_err_sticky", err_unexp_r, 1'b1);
    reset_pulse();
    chk("t5_err_clr", err_unexp_r, 1'b0);

    // Reset with two reads in flight and an AR pending.
    axi_arready   = 1'b1;
    req_araddr[0] = 32'h0000_2000;
    req_araddr[1] = 32'h0000_3000;
    req_arvalid   = 4'b0001;
    tick();
    req_arvalid = 4'b0010;
    tick();
    req_arvalid = '0;
    chk("t6_pre_arvalid", axi_arvalid, 1'b1);
    chk("t6_pre_count", dut.fifo_count, 3'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_arvalid", axi_arvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", dut.fifo_count, 3'd0);
    req_arvalid = 4'b0011;
    tick();
    chk("t6_first_grant", obs_arready, 4'b0001);
    drain();

    // Random traffic against the reference.
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < N_REQ; k++) req_araddr[k] = $urandom() & 32'hFFFF_FFC0;
      req_arvalid = N_REQ'($urandom());
      req_rready  = N_REQ'($urandom());
      axi_arready = ($urandom_range(3) != 0);
      axi_rvalid  = (q.size() > 0) && ($urandom_range(1) == 1);
      axi_rdata   = {16{$urandom()}};
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
